// File: rtl/datapath_ctrl.sv
// datapath_ctrl: sequencing FSM that latches one instruction per start/ready
// handshake and drives the register-file/shifter/ALU strobes for it.
// Ports: clk, reset_n (async, active-low); start/instr from the instruction source;
//   ready/done/illegal status; datapath_in (extended imm8), loada/loadb/loadc/loads,
//   asel/bsel/vsel, ALUop, shift, write, writenum, readnum towards the datapath.
module datapath_ctrl #(
   parameter logic SIGN_EXT = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] instr,
   output logic        ready,
   output logic        done,
   output logic        illegal,
   output logic [15:0] datapath_in,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic        vsel,
   output logic [1:0]  ALUop,
   output logic [1:0]  shift,
   output logic        write,
   output logic [2:0]  writenum,
   output logic [2:0]  readnum
);
   typedef enum logic [2:0] {IDLE, WR_IMM, GET_A, GET_B, EXEC, WR_C} state_t;
   state_t state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic done_q, done_d, illegal_q, illegal_d;
   logic in_movi, in_mov, in_alu, in_mvn, ir_mov, ir_cmp;
   assign in_movi = instr[15:11] == 5'b11010;
   assign in_mov  = instr[15:11] == 5'b11000;
   assign in_alu  = instr[15:13] == 3'b101;
   assign in_mvn  = instr[15:11] == 5'b10111;
   assign ir_mov  = ir_q[15:11] == 5'b11000;
   assign ir_cmp  = ir_q[15:11] == 5'b10101;
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            ir_d      = instr;
            // MOV and MVN ignore Rn, so they skip the A-load cycle
            state_d   = in_movi ? WR_IMM : (in_mov || in_mvn) ? GET_B : in_alu ? GET_A : IDLE;
            illegal_d = !(in_movi || in_mov || in_alu);
         end
         WR_IMM: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         GET_A: state_d = GET_B;
         GET_B: state_d = EXEC;
         EXEC: begin
            state_d = ir_cmp ? IDLE : WR_C;
            done_d  = ir_cmp;
         end
         WR_C: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ir_q      <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end
   always_comb begin
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = 1'b0;
      ALUop    = 2'b00;
      shift    = 2'b00;
      write    = 1'b0;
      writenum = 3'd0;
      readnum  = 3'd0;
      case (state_q)
         WR_IMM: begin
            write    = 1'b1;
            vsel     = 1'b1;
            writenum = ir_q[10:8];
         end
         GET_A: begin
            readnum = ir_q[10:8];
            loada   = 1'b1;
         end
         GET_B: begin
            readnum = ir_q[2:0];
            loadb   = 1'b1;
         end
         EXEC: begin
            shift = ir_q[4:3];
            ALUop = ir_q[12:11];
            loadc = 1'b1;
            // MOV is executed as 0 + shifted B
            asel  = ir_mov;
            loads = ir_cmp;
         end
         WR_C: begin
            write    = 1'b1;
            writenum = ir_q[7:5];
         end
         default: ;
      endcase
   end
   assign ready       = state_q == IDLE;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign datapath_in = {{8{SIGN_EXT & ir_q[7]}}, ir_q[7:0]};
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed bench with a datapath model and write/strobe scoreboards.
module tb_datapath_ctrl;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [15:0] instr = 16'h0;
   logic ready, done, illegal, loada, loadb, loadc, loads, asel, bsel, vsel, write;
   logic [15:0] datapath_in;
   logic [1:0] ALUop, shift;
   logic [2:0] writenum, readnum;
   logic ready0, done0, illegal0, loada0, loadb0, loadc0, loads0, asel0, bsel0, vsel0, write0;
   logic [15:0] datapath_in0;
   logic [1:0] ALUop0, shift0;
   logic [2:0] writenum0, readnum0;
   int errors = 0, checks = 0, done_cnt = 0;
   logic [18:0] sb[$];
   logic [17:0] exp_sig[$];
   logic [18:0] wr_exp;
   logic [15:0] R [8] = '{default: 16'h0};
   logic [15:0] A = 16'h0, B = 16'h0, C = 16'h0, bs, ain, bin, alu;
   logic [1:0] stat = 2'b00;

   datapath_ctrl #(.SIGN_EXT(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .ready(ready), .done(done),
      .illegal(illegal), .datapath_in(datapath_in), .loada(loada), .loadb(loadb), .loadc(loadc),
      .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
      .write(write), .writenum(writenum), .readnum(readnum));
   datapath_ctrl #(.SIGN_EXT(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .ready(ready0), .done(done0),
      .illegal(illegal0), .datapath_in(datapath_in0), .loada(loada0), .loadb(loadb0), .loadc(loadc0),
      .loads(loads0), .asel(asel0), .bsel(bsel0), .vsel(vsel0), .ALUop(ALUop0), .shift(shift0),
      .write(write0), .writenum(writenum0), .readnum(readnum0));

   always #5 clk = ~clk;

   always_comb begin
      bs  = shift == 2'b01 ? {B[14:0], 1'b0} : shift == 2'b10 ? {1'b0, B[15:1]} :
            shift == 2'b11 ? {B[15], B[15:1]} : B;
      ain = asel ? 16'h0 : A;
      bin = bsel ? {11'h0, datapath_in[4:0]} : bs;
      alu = ALUop == 2'b00 ? ain + bin : ALUop == 2'b01 ? ain - bin : ALUop == 2'b10 ? (ain & bin) : ~bin;
   end

   always @(posedge clk) begin
      if (loada) A <= R[readnum];
      if (loadb) B <= R[readnum];
      if (loadc) C <= alu;
      if (loads) stat <= {alu == 16'h0, alu[15]};
      if (write) R[writenum] <= vsel ? datapath_in : C;
   end

   function automatic logic [17:0] sig();
      return {loada, loadb, loadc, loads, asel, bsel, vsel, write, ALUop, shift, writenum, readnum};
   endfunction

   function automatic logic [17:0] mk(input logic la, lb, lc, ls, as, bsl, vs, wr,
                                      input logic [1:0] op, sh, input logic [2:0] wn, rn);
      return {la, lb, lc, ls, as, bsl, vs, wr, op, sh, wn, rn};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (write) begin
         chk("write_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            wr_exp = sb.pop_front();
            chk("write_data", 32'({writenum, vsel ? datapath_in : C}), 32'(wr_exp));
         end
      end
   end

   task automatic exec(input string tag, input logic [15:0] w, input int busy, input int poke);
      int n = 0;
      start = 1'b1;
      instr = w;
      @(negedge clk);
      start = 1'b0;
      instr = 16'($urandom);
      while (!ready && n < 20) begin
         n++;
         start = (n == poke);
         if (n == poke) instr = 16'hD7FF;
         chk({tag, "_seq"}, 32'(sig()), exp_sig.size() != 0 ? 32'(exp_sig.pop_front()) : 32'hFFFFFFFF);
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_busy"}, 32'(n), 32'(busy));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_seq_left"}, 32'(exp_sig.size()), 32'd0);
      chk({tag, "_wr_left"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_sig", 32'(sig()), 32'd0);
      chk("rst_flags", 32'({done, illegal}), 32'd0);
      chk("rst_dpin", 32'(datapath_in), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      // reset asserted in the middle of an ADD
      start = 1'b1;
      instr = 16'hA148;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_exec", 32'(sig()), 32'(mk(0,0,1,0,0,0,0,0,2'b00,2'b01,3'd0,3'd0)));
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_ready", 32'(ready), 32'd1);
      chk("async_rst_sig", 32'(sig()), 32'd0);
      chk("async_rst_flags", 32'({done, illegal}), 32'd0);
      chk("async_rst_dpin", 32'(datapath_in), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_no_write", 32'(R[2]), 32'd0);
      // MOVI R0,#7 and MOVI R1,#2
      sb.push_back({3'd0, 16'd7});
      exp_sig.push_back(mk(0,0,0,0,0,0,1,1,2'b00,2'b00,3'd0,3'd0));
      exec("movi0", 16'hD007, 1, 0);
      chk("movi0_dpin", 32'(datapath_in), 32'h0007);
      sb.push_back({3'd1, 16'd2});
      exp_sig.push_back(mk(0,0,0,0,0,0,1,1,2'b00,2'b00,3'd1,3'd0));
      exec("movi1", 16'hD102, 1, 0);
      chk("r0", 32'(R[0]), 32'd7);
      chk("r1", 32'(R[1]), 32'd2);
      // ADD R2,R1,R0 LSL 1
      sb.push_back({3'd2, 16'd16});
      exp_sig.push_back(mk(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd1));
      exp_sig.push_back(mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0));
      exp_sig.push_back(mk(0,0,1,0,0,0,0,0,2'b00,2'b01,3'd0,3'd0));
      exp_sig.push_back(mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'd2,3'd0));
      exec("add", 16'hA148, 4, 0);
      chk("add_c", 32'(C), 32'd16);
      chk("r2", 32'(R[2]), 32'd16);
      // CMP R1,R0
      exp_sig.push_back(mk(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd1));
      exp_sig.push_back(mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0));
      exp_sig.push_back(mk(0,0,1,1,0,0,0,0,2'b01,2'b00,3'd0,3'd0));
      exec("cmp", 16'hA900, 3, 0);
      chk("cmp_status", 32'(stat), 32'b01);
      // MOV R3,R0 LSR 1
      sb.push_back({3'd3, 16'd3});
      exp_sig.push_back(mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0));
      exp_sig.push_back(mk(0,0,1,0,1,0,0,0,2'b00,2'b10,3'd0,3'd0));
      exp_sig.push_back(mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'd3,3'd0));
      exec("mov", 16'hC070, 3, 0);
      chk("r3", 32'(R[3]), 32'd3);
      // MOVI R4,#-7: sign vs zero extension
      sb.push_back({3'd4, 16'hFFF9});
      exp_sig.push_back(mk(0,0,0,0,0,0,1,1,2'b00,2'b00,3'd4,3'd0));
      exec("movi4", 16'hD4F9, 1, 0);
      chk("dpin_sext", 32'(datapath_in), 32'hFFF9);
      chk("dpin_zext", 32'(datapath_in0), 32'h00F9);
      chk("r4", 32'(R[4]), 32'hFFF9);
      // illegal opcode
      start = 1'b1;
      instr = 16'hE000;
      @(negedge clk);
      start = 1'b0;
      chk("ill_pulse", 32'({illegal, ready, done}), 32'b110);
      chk("ill_sig", 32'(sig()), 32'd0);
      @(negedge clk);
      chk("ill_clear", 32'({illegal, ready}), 32'b01);
      chk("ill_sig2", 32'(sig()), 32'd0);
      // start pulsed while busy must be dropped
      sb.push_back({3'd2, 16'd16});
      exp_sig.push_back(mk(1,0,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd1));
      exp_sig.push_back(mk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'd0,3'd0));
      exp_sig.push_back(mk(0,0,1,0,0,0,0,0,2'b00,2'b01,3'd0,3'd0));
      exp_sig.push_back(mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'd2,3'd0));
      exec("busy_add", 16'hA148, 4, 2);
      @(negedge clk);
      chk("busy_ignored", 32'({ready, R[7]}), 32'h10000);
      // start held high: second MOVI accepted in the first IDLE cycle
      sb.push_back({3'd5, 16'd6});
      sb.push_back({3'd6, 16'd3});
      start = 1'b1;
      instr = 16'hD506;
      @(negedge clk);
      instr = 16'hD603;
      chk("b2b_first", 32'(sig()), 32'(mk(0,0,0,0,0,0,1,1,2'b00,2'b00,3'd5,3'd0)));
      @(negedge clk);
      chk("b2b_idle", 32'({ready, done}), 32'b11);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_second", 32'(sig()), 32'(mk(0,0,0,0,0,0,1,1,2'b00,2'b00,3'd6,3'd0)));
      @(negedge clk);
      chk("b2b_ready", 32'({ready, done}), 32'b11);
      @(negedge clk);
      chk("r5", 32'(R[5]), 32'd6);
      chk("r6", 32'(R[6]), 32'd3);
      chk("b2b_wr_left", 32'(sb.size()), 32'd0);
      chk("done_count", 32'(done_cnt), 32'd9);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Sequencing FSM for the 16-bit register-file/shifter/ALU datapath (ports datapath_in, loada, loadb, loadc, loads, asel, bsel, vsel, ALUop, shift, write, writenum, readnum).
- Accepts one 16-bit instruction per start/ready handshake and latches it.
- Drives the multi-cycle sequence of datapath strobes for that instruction, then returns to idle.
- Sits between the instruction source (bench or future fetch unit) and the datapath.

Parameters:
- SIGN_EXT, 1, 1 = imm8 is sign-extended to 16 bits on datapath_in; 0 = zero-extended.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to execute instr; sampled only in IDLE.
- instr  in  16  instruction word; sampled on the accepting edge.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse in the first IDLE cycle after a completed instruction.
- illegal  out  1  one-cycle pulse after an undefined opcode is accepted.
- datapath_in  out  16  extended imm8 of the latched instruction.
- loada, loadb, loadc, loads  out  1 each  datapath register enables.
- asel, bsel, vsel  out  1 each  datapath mux selects; vsel=1 writes datapath_in, vsel=0 writes C.
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B.
- shift  out  2  shifter control on the B path.
- write  out  1  register-file write enable.
- writenum, readnum  out  3 each  register-file addresses.

Behaviour:
- Instruction encoding (fields of the latched word ir):
  - [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.
  - 110/10 = MOVI Rn,#imm8
  - 110/00 = MOV Rd,Rm{,sh}
  - 101/00 = ADD Rd,Rn,Rm{,sh}
  - 101/01 = CMP Rn,Rm{,sh}
  - 101/10 = AND Rd,Rn,Rm{,sh}
  - 101/11 = MVN Rd,Rm{,sh}
  - Every other opcode/op pair is illegal.
- States: IDLE, WR_IMM, GET_A, GET_B, EXEC, WR_C.
- Transitions:
  - IDLE with start=1: ir <= instr, then go to:
    - MOVI → WR_IMM
    - ADD/CMP/AND → GET_A
    - MOV/MVN → GET_B
    - illegal → stay IDLE, pulse illegal next cycle, no strobes.
  - WR_IMM → IDLE.
  - GET_A → GET_B.
  - GET_B → EXEC.
  - EXEC → WR_C, except CMP → IDLE.
  - WR_C → IDLE.
- Outputs are Moore (decoded from state and ir). Every strobe is 0 outside the listed state; shift, ALUop, asel and bsel are 0 outside EXEC.
  - WR_IMM: write=1, vsel=1, writenum=Rn.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - EXEC:
    - shift=sh, bsel=0, loadc=1, ALUop=op.
    - asel=1 (A forced to 0) for MOV with ALUop=00; asel=0 otherwise.
    - loads=1 only for CMP.
  - WR_C: write=1, vsel=0, writenum=Rd.
- Busy-cycle latency from the accepting edge to ready=1: MOVI 1, ADD/AND 4, CMP 3, MOV/MVN 3. done is asserted together with that ready=1 cycle.
- datapath_in = {8{SIGN_EXT & ir[7]}, ir[7:0]}. It is held constant from the accepting edge until the next accepted instruction.
- Handshake boundaries:
  - start while busy is ignored, with no queuing.
  - Changes on instr while busy are ignored.
  - start held high continuously back-to-back: the next instruction is accepted in the first IDLE cycle.
- Reset: while reset_n=0 (asynchronous assertion), the following hold, including mid-sequence:
  - state=IDLE, ir=0, ready=1.
  - done=0, illegal=0, all strobes/selects/ALUop/shift/writenum/readnum=0, datapath_in=0.
  - No write is issued after reset is asserted.

Test Plan:
- Reset mid-EXEC of an ADD: assert reset_n=0 → all outputs 0 and ready=1 immediately, with no clock edge needed; after release the next start is accepted normally.
- MOVI sequence with a datapath model:
  - start with 0xD007, then 0xD102 → R0=7 and R1=2.
  - Each MOVI shows exactly one write=1, vsel=1 cycle.
  - ready returns 1 cycle after acceptance, and done pulses once per instruction.
- ADD 0xA148 (R2=R1+(R0 LSL 1)):
  - Cycle-exact sequence GET_A (readnum=1) → GET_B (readnum=0) → EXEC (shift=01, loadc) → WR_C (writenum=2, vsel=0).
  - datapath_out=16 and R2=16; 4 busy cycles.
- CMP 0xA900 with R1=2, R0=7: loads=1 only in EXEC, ALUop=01, write never asserted, 3 busy cycles.
- MOV 0xC070 with R0=7: asel=1, shift=10 in EXEC → R3=3.
- MOVI 0xD4F9 → datapath_in=0xFFF9 with SIGN_EXT=1 and 0x00F9 with SIGN_EXT=0.
- Illegal 0xE000: illegal pulses one cycle, no strobes, ready stays 1.
- start pulsed while busy: ignored, with no extra write.
